// File: rtl/shiftreg.sv
// Parallel-load, bidirectional shift register with a saturating shift counter
// and a registered flag raised once WIDTH shifts have completed since load/reset.
module shiftreg #(
  parameter int WIDTH = 8
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _load,
  input  logic [WIDTH-1:0] _D,
  input  logic             _shift,
  input  logic             _dir,
  input  logic             _serin,
  output logic [WIDTH-1:0] _Q,
  output logic             _serout,
  output logic             _full,
  output logic [WIDTH-1:0] _return
);

  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;

  // Next-state selection: load beats shift beats hold
  always_comb begin
    q_d    = q_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (_load) begin
      q_d    = _D;
      cnt_d  = {CW{1'b0}};
      full_d = 1'b0;
    end else if (_shift) begin
      if (_dir) begin
        q_d = {_serin, q_q[WIDTH-1:1]};
      end else begin
        q_d = {q_q[WIDTH-2:0], _serin};
      end
      // Saturate so the flag can never drop back through a wrap
      if (cnt_q == CNT_MAX) begin
        cnt_d  = cnt_q;
        full_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_ONE;
        full_d = ((cnt_q + CNT_ONE) == CNT_MAX);
      end
    end else begin
      q_d    = q_q;
      cnt_d  = cnt_q;
      full_d = full_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      q_q    <= {WIDTH{1'b0}};
      cnt_q  <= {CW{1'b0}};
      full_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  assign _Q      = q_q;
  assign _return = q_q;
  assign _full   = full_q;
  assign _serout = _dir ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: tb/tb_shiftreg.sv
// Self-checking bench for shiftreg (WIDTH=8): arithmetic reference model checked
// every falling edge, plus hand-computed literal checkpoints.
module tb_shiftreg;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0, shift = 1'b0, dir = 1'b0, serin = 1'b0;
  logic [W-1:0] d = 8'h00;
  logic [W-1:0] q, ret;
  logic         serout, full;

  int n_cmp = 0;
  int n_fail = 0;

  int unsigned m_q   = 0;
  int          m_cnt = 0;

  shiftreg #(.WIDTH(W)) dut (
    ._clock(clk), ._reset(rst_n), ._load(load), ._D(d), ._shift(shift),
    ._dir(dir), ._serin(serin), ._Q(q), ._serout(serout), ._full(full),
    ._return(ret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the register value and shift count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= 0;
      m_cnt <= 0;
    end else if (load) begin
      m_q   <= d;
      m_cnt <= 0;
    end else if (shift) begin
      if (dir) m_q <= (m_q >> 1) | (serin ? 32'd128 : 32'd0);
      else     m_q <= ((m_q << 1) | serin) & 32'hFF;
      m_cnt <= (m_cnt < W) ? m_cnt + 1 : m_cnt;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("model_q", q, m_q);
    chk("model_return", ret, m_q);
    chk("model_full", full, (m_cnt == W) ? 32'd1 : 32'd0);
    chk("model_serout", serout, dir ? m_q[0] : m_q[W-1]);
  end

  task automatic step(input logic l, input logic [W-1:0] dd, input logic s,
                      input logic dr, input logic si);
    load = l; d = dd; shift = s; dir = dr; serin = si;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset held: edges with load/shift must be ignored
    load = 1'b1; d = 8'hFF; shift = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_full", full, 1'b0);
    chk("rst_serout", serout, 1'b0);
    rst_n = 1'b1;

    // First edge after release acts normally
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("load_a5", q, 8'hA5);
    chk("serout_left", serout, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("left_shift", q, 8'h4B);
    chk("left_serout", serout, 1'b0);

    // Async reset between edges, with load+shift asserted
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    load = 1'b1; d = 8'h77; shift = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_q", q, 8'h00);
    chk("async_full", full, 1'b0);
    chk("async_return", ret, 8'h00);
    @(posedge clk); #1;
    chk("rst_override", q, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Right shift
    step(1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
    chk("serout_right", serout, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("right_shift", q, 8'h40);
    chk("right_serout", serout, 1'b0);
    dir = 1'b0; #1;
    chk("serout_dir_follow", serout, 1'b0);
    dir = 1'b1; #1;

    // Priority: load wins over shift
    step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    chk("prio_q", q, 8'h3C);
    chk("prio_full", full, 1'b0);

    // Full flag
    step(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("full_after7", full, 1'b0);
    chk("q_after7", q, 8'h7F);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("q_after8", q, 8'hFF);
    chk("full_after8", full, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("full_after9", full, 1'b1);
    chk("q_after9", q, 8'hFE);
    step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    chk("full_load_clear", full, 1'b0);

    // Mixed directions all count toward full
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, i[0], 1'b0);
    chk("mixdir_full7", full, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("mixdir_full8", full, 1'b1);

    // Hold
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, i[0], 1'b1);
    chk("hold_q", q, 8'h5A);
    chk("hold_full", full, 1'b0);

    // Pseudo-random traffic checked by the model
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/shiftreg.md
SHIFTREG -- requirements
Module: shiftreg

Interface
REQ-001: Parameter WIDTH, default 8, register width in bits; legal range WIDTH >= 2.
REQ-002: Port _clock  input  1  single clock; all state updates occur on its rising edge.
REQ-003: Port _reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, without waiting for a clock edge.
REQ-004: Port _load  input  1  parallel-load strobe, sampled on the rising edge of _clock.
REQ-005: Port _D  input  WIDTH  parallel load data.
REQ-006: Port _shift  input  1  shift-enable strobe, sampled on the rising edge of _clock.
REQ-007: Port _dir  input  1  shift direction: 0 = toward MSB (left), 1 = toward LSB (right).
REQ-008: Port _serin  input  1  serial data shifted into the vacated end.
REQ-009: Port _Q  output  WIDTH  registered parallel contents.
REQ-010: Port _serout  output  1  bit about to leave the register, combinational from _Q and _dir.
REQ-011: Port _full  output  1  registered flag: WIDTH shifts have completed since the last load or reset.
REQ-012: Port _return  output  WIDTH  identical to _Q.

Function
REQ-013: On each rising edge with _reset high, the block SHALL select exactly one action, in priority order: load, shift, hold.
REQ-014: Load (_load=1) SHALL set _Q to _D, clear the shift count to 0, and clear _full, regardless of _shift.
REQ-015: Left shift (_load=0, _shift=1, _dir=0) SHALL set _Q to {_Q[WIDTH-2:0], _serin}.
REQ-016: Right shift (_load=0, _shift=1, _dir=1) SHALL set _Q to {_serin, _Q[WIDTH-1:1]}.
REQ-017: Hold (_load=0, _shift=0) SHALL leave _Q, the count and _full unchanged.
REQ-018: _serout SHALL equal _Q[WIDTH-1] when _dir=0 and _Q[0] when _dir=1, and SHALL follow a _dir change within the same cycle.
REQ-019: An internal shift counter of clog2(WIDTH+1) bits SHALL increment by 1 on each shift and saturate at WIDTH; it SHALL never wrap.
REQ-020: _full SHALL be 1 exactly when the count equals WIDTH, and SHALL update on the same edge as the WIDTH-th shift, with no extra latency.
REQ-021: Shifting while _full=1 SHALL still shift _Q; _full SHALL remain 1.
REQ-022: A _dir change between shifts SHALL be legal; each shift SHALL count toward _full regardless of direction.
REQ-023: Latency from a sampled _load or _shift to updated _Q SHALL be one clock edge.
REQ-024: _return SHALL equal _Q at all times.

Reset
REQ-025: While _reset is low, _Q SHALL be 0, the count SHALL be 0, _full SHALL be 0, and _serout SHALL be 0; clock edges SHALL be ignored.
REQ-026: Reset assertion mid-operation, including in the same cycle as _load or _shift, SHALL override all other inputs.
REQ-027: On the first rising edge after _reset returns high, the block SHALL act on _load/_shift normally.

Verification (WIDTH=8)
REQ-028: Async reset: _Q=8'hA5 loaded, drive _reset low between clock edges -> _Q=8'h00 and _full=0 before the next edge.
REQ-029: Left shift: load 8'hA5; _dir=0 -> _serout=1; one shift with _serin=1 -> _Q=8'h4B, _serout=0.
REQ-030: Right shift: load 8'h81; _dir=1 -> _serout=1; one shift with _serin=0 -> _Q=8'h40, _serout=0.
REQ-031: Priority: _load=1, _D=8'h3C, _shift=1 on the same edge -> _Q=8'h3C, count 0, _full=0.
REQ-032: Full flag: load 8'h00, then 8 left shifts with _serin=1 -> _full=0 after 7 shifts; _Q=8'hFF and _full=1 after the 8th; a 9th shift keeps _full=1; a following load clears _full to 0.
REQ-033: Hold: load 8'h5A, then 3 edges with _load=0 and _shift=0 -> _Q stays 8'h5A, _full stays 0.
